// File: rtl/irq_controller.sv
// Machine-level interrupt controller: edge-captured external sources, prescaled mtime/mtimecmp
// timer, enable mask and fixed-priority selection. It holds one request until ack, then waits for mret.
module irq_controller #(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned TIMER_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_in,
  input  logic             bus_we,
  input  logic [2:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  input  logic             irq_ack,
  input  logic             irq_complete,
  output logic             interrupt,
  output logic [31:0]      irq_cause,
  output logic [4:0]       irq_id
);

  localparam int unsigned PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [31:0] CauseTimer = 32'h8000_0007;
  localparam logic [31:0] CauseExt   = 32'h8000_000B;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StService = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             interrupt_q, interrupt_d;
  logic [31:0]      cause_q, cause_d;
  logic [4:0]       id_q, id_d;
  logic [N_SRC-1:0] ext_pend_q, ext_pend_d;
  logic [N_SRC-1:0] src_prev_q;
  logic [N_SRC:0]   enable_q, enable_d;
  logic [31:0]      mtime_q, mtime_d;
  logic [31:0]      mtimecmp_q, mtimecmp_d;
  logic [PW-1:0]    presc_q, presc_d;

  logic             timer_pend;
  logic [N_SRC:0]   eligible;
  logic [4:0]       sel;
  logic             latched_elig;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] w1c;

  assign timer_pend = (mtime_q >= mtimecmp_q);
  assign eligible   = {ext_pend_q, timer_pend} & enable_q;

  // Lowest id wins; also look up whether the latched id is still eligible.
  always_comb begin
    sel          = '0;
    latched_elig = 1'b0;
    for (int i = N_SRC; i >= 0; i--) begin
      if (eligible[i]) sel = 5'(i);
      if (id_q == 5'(i)) latched_elig = eligible[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    interrupt_d = interrupt_q;
    cause_d     = cause_q;
    id_d        = id_q;
    ack_clr     = '0;
    unique case (state_q)
      StIdle: begin
        if (|eligible) begin
          state_d     = StReq;
          interrupt_d = 1'b1;
          id_d        = sel;
          cause_d     = (sel == 5'd0) ? CauseTimer : CauseExt;
        end
      end
      StReq: begin
        if (irq_ack) begin
          state_d     = StService;
          interrupt_d = 1'b0;
          for (int i = 0; i < N_SRC; i++) begin
            if (id_q == 5'(i + 1)) ack_clr[i] = 1'b1;
          end
        end else if (!latched_elig) begin
          state_d     = StIdle;
          interrupt_d = 1'b0;
        end
      end
      StService: begin
        if (irq_complete) state_d = StIdle;
      end
      default: begin
        state_d     = StIdle;
        interrupt_d = 1'b0;
      end
    endcase
  end

  // A fresh edge beats a same-cycle clear (W1C or ack).
  always_comb begin
    w1c        = (bus_we && bus_addr == 3'd0) ? bus_wdata[N_SRC:1] : '0;
    ext_pend_d = (ext_pend_q & ~w1c & ~ack_clr) | (src_in & ~src_prev_q);
  end

  always_comb begin
    enable_d   = enable_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = mtime_q;
    presc_d    = presc_q;
    if (bus_we && bus_addr == 3'd1) enable_d = bus_wdata[N_SRC:0];
    if (bus_we && bus_addr == 3'd3) mtimecmp_d = bus_wdata;
    if (bus_we && bus_addr == 3'd2) begin
      mtime_d = bus_wdata;
      presc_d = '0;
    end else if (presc_q == PW'(TIMER_DIV - 1)) begin
      mtime_d = mtime_q + 32'd1;
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_comb begin
    bus_rdata = '0;
    case (bus_addr)
      3'd0:    bus_rdata = 32'({ext_pend_q, timer_pend});
      3'd1:    bus_rdata = 32'(enable_q);
      3'd2:    bus_rdata = mtime_q;
      3'd3:    bus_rdata = mtimecmp_q;
      3'd4:    bus_rdata = {19'd0, id_q, 6'd0, state_q};
      default: bus_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      interrupt_q <= 1'b0;
      cause_q     <= '0;
      id_q        <= '0;
      ext_pend_q  <= '0;
      src_prev_q  <= '0;
      enable_q    <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= 32'hFFFF_FFFF;
      presc_q     <= '0;
    end else begin
      state_q     <= state_d;
      interrupt_q <= interrupt_d;
      cause_q     <= cause_d;
      id_q        <= id_d;
      ext_pend_q  <= ext_pend_d;
      src_prev_q  <= src_in;
      enable_q    <= enable_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      presc_q     <= presc_d;
    end
  end

  assign interrupt = interrupt_q;
  assign irq_cause = cause_q;
  assign irq_id    = id_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the controller.
module tb_irq_controller;

  localparam int unsigned N_SRC     = 4;
  localparam int unsigned TIMER_DIV = 4;

  logic             clk;
  logic             rst;
  logic [N_SRC-1:0] src_in;
  logic             bus_we;
  logic [2:0]       bus_addr;
  logic [31:0]      bus_wdata;
  logic [31:0]      bus_rdata;
  logic             irq_ack;
  logic             irq_complete;
  logic             interrupt;
  logic [31:0]      irq_cause;
  logic [4:0]       irq_id;

  int n_vec = 0;
  int n_err = 0;

  irq_controller #(.N_SRC(N_SRC), .TIMER_DIV(TIMER_DIV)) dut (
    .clk(clk), .rst(rst), .src_in(src_in), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq_ack(irq_ack),
    .irq_complete(irq_complete), .interrupt(interrupt), .irq_cause(irq_cause), .irq_id(irq_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: mtime is derived from the last written base and elapsed cycles.
  bit              m_ext [1:N_SRC];
  logic [N_SRC:0]  m_en;
  longint unsigned m_base, m_tick;
  logic [31:0]     m_cmp;
  logic [N_SRC-1:0] m_prev;
  int              m_state;  // 0 idle, 1 request, 2 service
  logic            m_irq;
  logic [31:0]     m_cause;
  int              m_id;

  function automatic logic [31:0] model_mtime();
    return 32'((m_base + m_tick / TIMER_DIV) % 64'h1_0000_0000);
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] r = '0;
    case (a)
      3'd0: begin
        r[0] = (model_mtime() >= m_cmp);
        for (int i = 1; i <= N_SRC; i++) r[i] = m_ext[i];
      end
      3'd1: r = 32'(m_en);
      3'd2: r = model_mtime();
      3'd3: r = m_cmp;
      3'd4: r = 32'(m_state) | (32'(m_id) << 8);
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_step();
    bit elig [0:N_SRC];
    bit nxt [1:N_SRC];
    int sel = -1;
    if (rst) begin
      for (int i = 1; i <= N_SRC; i++) m_ext[i] = 0;
      m_en = '0; m_base = 0; m_tick = 0; m_cmp = 32'hFFFF_FFFF; m_prev = '0;
      m_state = 0; m_irq = 0; m_cause = '0; m_id = 0;
      return;
    end
    for (int i = 0; i <= N_SRC; i++) begin
      elig[i] = m_en[i] && ((i == 0) ? (model_mtime() >= m_cmp) : m_ext[i]);
      if (elig[i] && sel < 0) sel = i;
    end
    for (int i = 1; i <= N_SRC; i++) begin
      bit cleared = (bus_we && bus_addr == 3'd0 && bus_wdata[i]) ||
                    (m_state == 1 && irq_ack && m_id == i);
      nxt[i] = (src_in[i-1] && !m_prev[i-1]) || (m_ext[i] && !cleared);
    end
    if (m_state == 0 && sel >= 0) begin
      m_state = 1; m_irq = 1; m_id = sel;
      m_cause = (sel == 0) ? 32'h8000_0007 : 32'h8000_000B;
    end else if (m_state == 1 && irq_ack) begin
      m_state = 2; m_irq = 0;
    end else if (m_state == 1 && !elig[m_id]) begin
      m_state = 0; m_irq = 0;
    end else if (m_state == 2 && irq_complete) begin
      m_state = 0;
    end
    for (int i = 1; i <= N_SRC; i++) m_ext[i] = nxt[i];
    if (bus_we && bus_addr == 3'd1) m_en = bus_wdata[N_SRC:0];
    if (bus_we && bus_addr == 3'd3) m_cmp = bus_wdata;
    if (bus_we && bus_addr == 3'd2) begin
      m_base = bus_wdata; m_tick = 0;
    end else begin
      m_tick++;
    end
    m_prev = src_in;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    step();
    bus_we = 1'b0; bus_wdata = '0;
  endtask

  task automatic rd(input logic [2:0] a);
    bus_addr = a;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_vec++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b exp 0", interrupt); end
    n_vec++; if (irq_cause !== 32'd0) begin n_err++; $display("FAIL reset_cause got %h exp 0", irq_cause); end
    n_vec++; if (irq_id !== 5'd0) begin n_err++; $display("FAIL reset_id got %0d exp 0", irq_id); end
    rd(3'd0);
    n_vec++; if (bus_rdata !== 32'd0) begin n_err++; $display("FAIL reset_pending got %h exp 0", bus_rdata); end
    rd(3'd3);
    n_vec++; if (bus_rdata !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_mtimecmp got %h exp ffffffff", bus_rdata); end
    rd(3'd4);
    n_vec++; if (bus_rdata !== 32'd0) begin n_err++; $display("FAIL reset_status got %h exp 0", bus_rdata); end
  endtask

  task automatic test_single_source();
    wr(3'd1, 32'h2);
    src_in = 4'b0001;
    step();
    src_in = '0;
    rd(3'd0);
    n_vec++; if (bus_rdata !== 32'h2) begin n_err++; $display("FAIL single_pending got %h exp 2", bus_rdata); end
    n_vec++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL single_early_irq got %b exp 0", interrupt); end
    step();
    n_vec++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL single_irq got %b exp 1", interrupt); end
    n_vec++; if (irq_id !== 5'd1) begin n_err++; $display("FAIL single_id got %0d exp 1", irq_id); end
    n_vec++; if (irq_cause !== 32'h8000_000B) begin n_err++; $display("FAIL single_cause got %h exp 8000000b", irq_cause); end
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    n_vec++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL single_ack_irq got %b exp 0", interrupt); end
    rd(3'd0);
    n_vec++; if (bus_rdata !== 32'h0) begin n_err++; $display("FAIL single_ack_pending got %h exp 0", bus_rdata); end
    rd(3'd4);
    n_vec++; if (bus_rdata[1:0] !== 2'd2) begin n_err++; $display("FAIL single_service got %0d exp 2", bus_rdata[1:0]); end
    irq_complete = 1'b1; step(); irq_complete = 1'b0;
    rd(3'd4);
    n_vec++; if (bus_rdata[1:0] !== 2'd0) begin n_err++; $display("FAIL single_complete got %0d exp 0", bus_rdata[1:0]); end
  endtask

  task automatic test_priority();
    wr(3'd1, 32'h6);
    src_in = 4'b0011; step(); src_in = '0;
    step();
    n_vec++; if (irq_id !== 5'd1 || interrupt !== 1'b1) begin n_err++; $display("FAIL prio_first got id %0d irq %b exp id 1 irq 1", irq_id, interrupt); end
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    irq_complete = 1'b1; step(); irq_complete = 1'b0;
    step();
    n_vec++; if (irq_id !== 5'd2 || interrupt !== 1'b1) begin n_err++; $display("FAIL prio_second got id %0d irq %b exp id 2 irq 1", irq_id, interrupt); end
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    irq_complete = 1'b1; step(); irq_complete = 1'b0;
  endtask

  task automatic test_timer();
    int found = 0;
    rst = 1'b1; step(); rst = 1'b0;
    wr(3'd3, 32'd3);
    wr(3'd1, 32'h1);
    for (int k = 1; k <= 20 && found == 0; k++) begin
      step();
      if (interrupt) found = k;
    end
    n_vec++; if (found !== 11) begin n_err++; $display("FAIL timer_latency got %0d exp 11", found); end
    n_vec++; if (irq_cause !== 32'h8000_0007) begin n_err++; $display("FAIL timer_cause got %h exp 80000007", irq_cause); end
    n_vec++; if (irq_id !== 5'd0) begin n_err++; $display("FAIL timer_id got %0d exp 0", irq_id); end
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    irq_complete = 1'b1; step(); irq_complete = 1'b0;
    step();
    n_vec++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL timer_reassert got %b exp 1", interrupt); end
    wr(3'd3, 32'hFFFF_FFFF);
    step();
    rd(3'd4);
    n_vec++; if (interrupt !== 1'b0 || bus_rdata[1:0] !== 2'd0) begin n_err++; $display("FAIL timer_withdraw got irq %b state %0d exp 0 0", interrupt, bus_rdata[1:0]); end
  endtask

  task automatic test_w1c_in_req();
    bit saw_service = 0;
    wr(3'd1, 32'h2);
    src_in = 4'b0001; step(); src_in = '0;
    step();
    n_vec++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL w1c_req got %b exp 1", interrupt); end
    wr(3'd0, 32'h2);
    rd(3'd4); if (bus_rdata[1:0] == 2'd2) saw_service = 1;
    step();
    rd(3'd4); if (bus_rdata[1:0] == 2'd2) saw_service = 1;
    n_vec++; if (interrupt !== 1'b0 || bus_rdata[1:0] !== 2'd0) begin n_err++; $display("FAIL w1c_drop got irq %b state %0d exp 0 0", interrupt, bus_rdata[1:0]); end
    n_vec++; if (saw_service !== 1'b0) begin n_err++; $display("FAIL w1c_no_service got %b exp 0", saw_service); end
  endtask

  task automatic test_wrap_and_set_wins();
    rst = 1'b1; step(); rst = 1'b0;
    wr(3'd2, 32'hFFFF_FFFF);
    rd(3'd2);
    n_vec++; if (bus_rdata !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_write got %h exp ffffffff", bus_rdata); end
    for (int k = 0; k < TIMER_DIV; k++) step();
    rd(3'd2);
    n_vec++; if (bus_rdata !== 32'd0) begin n_err++; $display("FAIL wrap_zero got %h exp 0", bus_rdata); end
    src_in = 4'b0001;
    wr(3'd0, 32'h2);
    rd(3'd0);
    n_vec++; if (bus_rdata !== 32'h2) begin n_err++; $display("FAIL set_wins got %h exp 2", bus_rdata); end
    wr(3'd0, 32'h2);
    step();
    rd(3'd0);
    n_vec++; if (bus_rdata !== 32'h0) begin n_err++; $display("FAIL level_no_reset got %h exp 0", bus_rdata); end
    src_in = '0;
  endtask

  task automatic test_reset_in_service();
    wr(3'd1, 32'h2);
    src_in = 4'b0001; step(); src_in = '0;
    step();
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    rd(3'd4);
    n_vec++; if (bus_rdata[1:0] !== 2'd2) begin n_err++; $display("FAIL rst_pre_service got %0d exp 2", bus_rdata[1:0]); end
    wr(3'd3, 32'd5);
    rst = 1'b1; step(); rst = 1'b0;
    n_vec++; if (interrupt !== 1'b0 || irq_id !== 5'd0 || irq_cause !== 32'd0) begin n_err++; $display("FAIL rst_outputs got irq %b id %0d cause %h exp 0 0 0", interrupt, irq_id, irq_cause); end
    rd(3'd0);
    n_vec++; if (bus_rdata !== 32'd0) begin n_err++; $display("FAIL rst_pending got %h exp 0", bus_rdata); end
    rd(3'd3);
    n_vec++; if (bus_rdata !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rst_mtimecmp got %h exp ffffffff", bus_rdata); end
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    irq_complete = 1'b1; step(); irq_complete = 1'b0;
    rd(3'd4);
    n_vec++; if (bus_rdata !== 32'd0 || interrupt !== 1'b0) begin n_err++; $display("FAIL idle_ignore got status %h irq %b exp 0 0", bus_rdata, interrupt); end
  endtask

  task automatic test_random();
    rst = 1'b1; step(); rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rst          = ($urandom_range(0, 199) == 0);
      src_in       = N_SRC'($urandom);
      irq_ack      = interrupt ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      irq_complete = ($urandom_range(0, 3) == 0);
      bus_we       = ($urandom_range(0, 4) == 0);
      bus_addr     = 3'($urandom);
      if (bus_addr == 3'd3 || bus_addr == 3'd2)
        bus_wdata = $urandom_range(0, 1) ? model_mtime() + 32'($urandom_range(0, 12)) : $urandom;
      else if (bus_addr == 3'd1)
        bus_wdata = $urandom_range(0, 3) == 0 ? $urandom : 32'h1F;
      else
        bus_wdata = $urandom;
      #1;
      n_vec++; if (bus_rdata !== model_read(bus_addr)) begin n_err++; $display("FAIL rand_rdata addr %0d got %h exp %h", bus_addr, bus_rdata, model_read(bus_addr)); end
      step();
      n_vec++;
      if (interrupt !== m_irq || irq_id !== 5'(m_id) || irq_cause !== m_cause) begin
        n_err++;
        $display("FAIL rand_outputs cyc %0d got irq %b id %0d cause %h exp irq %b id %0d cause %h",
                 c, interrupt, irq_id, irq_cause, m_irq, m_id, m_cause);
      end
    end
    rst = 1'b0; bus_we = 1'b0; irq_ack = 1'b0; irq_complete = 1'b0; src_in = '0;
  endtask

  initial begin
    rst = 1'b1; src_in = '0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    irq_ack = 1'b0; irq_complete = 1'b0;
    test_reset();
    test_single_source();
    test_priority();
    test_timer();
    test_w1c_in_req();
    test_wrap_and_set_wins();
    test_reset_in_service();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Machine-level interrupt controller that drives the `interrupt` input of the pipeline exception unit.
- Internals:
  - Edge-captures N_SRC external interrupt lines into a pending register.
  - Runs a prescaled 32-bit mtime/mtimecmp timer.
  - Masks sources with an enable register.
  - Picks one source by fixed priority.
- Holds the request until the core acknowledges trap entry, then blocks further requests until the handler's mret signals completion.
- Sits beside the exception unit; software configures it through a small register port.

Parameters:
N_SRC, 4, number of external interrupt sources (1..31)
TIMER_DIV, 4, clock cycles per mtime increment (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
src_in  in  N_SRC  external interrupt lines, same clock domain, rising-edge triggered
bus_we  in  1  register write strobe
bus_addr  in  3  register index
bus_wdata  in  32  write data
bus_rdata  out  32  read data, combinational from bus_addr
irq_ack  in  1  core entered trap for the presented request (exception unit trap taken)
irq_complete  in  1  mret retired
interrupt  out  1  request to exception unit, registered
irq_cause  out  32  mcause value for presented request
irq_id  out  5  id of presented/in-service source

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values:
  - state=IDLE; interrupt=0; irq_cause=0; irq_id=0.
  - pending=0; enable=0; mtime=0; prescaler=0; src_prev=0.
  - mtimecmp=32'hFFFFFFFF.
- Source ids:
  - Id 0 = timer. Ids 1..N_SRC = src_in[0..N_SRC-1].
  - Lower id = higher priority.
- Registers (index: name):
  - 0: PENDING. Bit0 = timer (read-only, equals mtime>=mtimecmp, unsigned). Bits 1..N_SRC = external pending; write-1-to-clear.
  - 1: ENABLE. Bits 0..N_SRC RW; other bits read 0.
  - 2: MTIME, RW.
  - 3: MTIMECMP, RW.
  - 4: STATUS, read-only. [1:0]=state (0 IDLE, 1 REQ, 2 SERVICE); [12:8]=irq_id.
  - 5-7: read 0; writes ignored.
- Edge capture:
  - External bit sets when src_in=1 and src_prev=0 at a clock edge.
  - Set wins over a same-cycle W1C of that bit.
  - Level held high does not re-set after clearing.
- Timer:
  - Prescaler counts 0..TIMER_DIV-1; mtime increments when prescaler=TIMER_DIV-1.
  - mtime wraps 32'hFFFFFFFF -> 0.
  - Write to MTIME overrides that cycle's increment and zeroes the prescaler.
- Candidate set: eligible = pending & enable; selected = lowest set id.
- FSM:
  - IDLE: if eligible != 0 -> REQ. Latch irq_id=selected and irq_cause; interrupt=1 from the next cycle.
  - irq_cause values: timer 32'h80000007; external 32'h8000000B.
  - REQ: interrupt held 1; irq_id/irq_cause stable.
    - irq_ack=1 -> SERVICE, interrupt=0; external pending bit for irq_id cleared in the same edge; timer bit is not cleared.
    - Else if the latched source is no longer eligible (W1C or enable cleared) -> IDLE, interrupt=0.
    - A higher-priority arrival during REQ does not preempt.
  - SERVICE: interrupt=0; new pending still captured. irq_complete=1 -> IDLE. irq_id retained until the next REQ.
- irq_ack outside REQ is ignored; irq_complete outside SERVICE is ignored. Both asserted in REQ: ack is processed, complete is ignored.
- No nesting; at most one request outstanding.
- Latency: src_in rising in cycle t -> PENDING bit visible t+1 -> interrupt=1 at t+2 (if enabled, state IDLE).
- rst mid-operation: everything returns to reset values on the next edge; interrupt drops in that cycle.

Test Plan:
- Reset, ENABLE=0x2, pulse src_in[0] for 1 cycle at t -> PENDING=0x2 at t+1; interrupt=1, irq_id=1, irq_cause=32'h8000000B at t+2; irq_ack -> interrupt=0, PENDING=0, STATUS[1:0]=2; irq_complete -> STATUS[1:0]=0.
- ENABLE=0x6, src_in[0] and src_in[1] rise in the same cycle -> irq_id=1 first; after ack+complete, second request irq_id=2 appears 1 cycle later.
- TIMER_DIV=4, MTIMECMP=3, ENABLE=0x1 -> mtime reaches 3 after 12 cycles; interrupt=1 one cycle later, irq_cause=32'h80000007; after ack+complete, request reasserts until MTIMECMP is rewritten to 32'hFFFFFFFF.
- In REQ for id 1, write PENDING=0x2 (W1C) before ack -> interrupt=0 next cycle, state IDLE, no SERVICE.
- Write MTIME=32'hFFFFFFFF -> wraps to 0 after TIMER_DIV cycles. Same-cycle edge on src_in[0] and W1C of bit 1 -> bit 1 stays set.
- Assert rst while in SERVICE -> next cycle all outputs 0, PENDING=0, MTIMECMP=32'hFFFFFFFF; irq_ack/irq_complete pulses in IDLE cause no state change.
